// File: rtl/pix_reset_seq.sv
// Pixel-domain reset sequencer: synchronizes clk_locked, qualifies a stable lock, then releases rst_pix.
// Define PIX_RESET_SEQ_LOSS_CNT_EN to build the saturating lock-loss counter; otherwise lost_count is 0.
module pix_reset_seq #(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 1024,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOST_W        = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clk_locked,
  output logic              rst_pix,
  output logic              ready,
  output logic              lost_pulse,
  output logic [LOST_W-1:0] lost_count
);

  // One counter serves both lock qualification and the post-loss hold.
  localparam int CNT_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    RUN       = 2'd2,
    LOST      = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic       rst_pix_q, rst_pix_d;
  logic       ready_q, ready_d;
  logic       lost_pulse_q, lost_pulse_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[SYNC_STAGES-2:0], clk_locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rst_pix_d    = 1'b1;
    lost_pulse_d = 1'b0;
    case (state_q)
      WAIT_LOCK: begin
        cnt_d = '0;
        if (locked_s) begin
          state_d = STABLE;
          cnt_d   = CNT_ONE;
        end
      end
      STABLE: begin
        // A drop before qualification completes is a glitch, not a loss.
        if (!locked_s) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == STABLE_LAST) begin
          state_d   = RUN;
          cnt_d     = '0;
          rst_pix_d = 1'b0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      RUN: begin
        rst_pix_d = 1'b0;
        if (!locked_s) begin
          state_d      = LOST;
          cnt_d        = '0;
          rst_pix_d    = 1'b1;
          lost_pulse_d = 1'b1;
        end
      end
      LOST: begin
        // Lock state is ignored for the whole hold; requalification restarts from zero.
        if (cnt_q == HOLD_LAST) begin
          state_d = WAIT_LOCK;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
    endcase
    ready_d = ~rst_pix_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= WAIT_LOCK;
      cnt_q        <= '0;
      rst_pix_q    <= 1'b1;
      ready_q      <= 1'b0;
      lost_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      rst_pix_q    <= rst_pix_d;
      ready_q      <= ready_d;
      lost_pulse_q <= lost_pulse_d;
    end
  end

`ifdef PIX_RESET_SEQ_LOSS_CNT_EN
  logic [LOST_W-1:0] lost_count_q, lost_count_d;

  always_comb begin
    lost_count_d = lost_count_q;
    if (lost_pulse_d && (lost_count_q != '1)) lost_count_d = lost_count_q + LOST_W'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lost_count_q <= '0;
    else        lost_count_q <= lost_count_d;
  end

  assign lost_count = lost_count_q;
`else
  assign lost_count = '0;
`endif

  assign rst_pix    = rst_pix_q;
  assign ready      = ready_q;
  assign lost_pulse = lost_pulse_q;

endmodule

// File: tb/tb_pix_reset_seq.sv
// Scoreboard bench for pix_reset_seq: a run-length reference model predicts every cycle's outputs.
module tb_pix_reset_seq;
  localparam int SYNC_STAGES   = 2;
  localparam int STABLE_CYCLES = 8;
  localparam int HOLD_CYCLES   = 4;
  localparam int LOST_W        = 2;
  localparam int LOSS_SAT      = (1 << LOST_W) - 1;

  logic clk = 1'b1;
  logic rst_n = 1'b0;
  logic clk_locked = 1'b0;
  logic rst_pix, ready, lost_pulse;
  logic [LOST_W-1:0] lost_count;

  typedef struct packed {
    logic              rst_pix;
    logic              ready;
    logic              lost_pulse;
    logic [LOST_W-1:0] lost_count;
  } exp_t;

  exp_t sb_q[$];
  int errors = 0;
  int checks = 0;

  // Reference model: delayed lock samples, run length of good lock, hold remaining, loss tally.
  bit hist[$];
  int run_len, hold_left, losses;
  bit released, pulse;

  pix_reset_seq #(
    .SYNC_STAGES(SYNC_STAGES), .STABLE_CYCLES(STABLE_CYCLES),
    .HOLD_CYCLES(HOLD_CYCLES), .LOST_W(LOST_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .clk_locked(clk_locked),
    .rst_pix(rst_pix), .ready(ready), .lost_pulse(lost_pulse), .lost_count(lost_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_out();
    exp_t e;
    e.rst_pix    = !released;
    e.ready      = released;
    e.lost_pulse = pulse;
`ifdef PIX_RESET_SEQ_LOSS_CNT_EN
    e.lost_count = LOST_W'(losses);
`else
    e.lost_count = '0;
`endif
    return e;
  endfunction

  function automatic void model_reset();
    hist.delete();
    for (int i = 0; i < SYNC_STAGES; i++) hist.push_back(1'b0);
    run_len = 0; hold_left = 0; losses = 0; released = 0; pulse = 0;
  endfunction

  function automatic void model_edge(bit lk);
    bit s;
    s = hist.pop_front();
    hist.push_back(lk);
    pulse = 0;
    if (hold_left > 0) begin
      hold_left--;
    end else if (!released) begin
      run_len = s ? run_len + 1 : 0;
      if (run_len == STABLE_CYCLES) begin
        released = 1;
        run_len  = 0;
      end
    end else if (!s) begin
      released  = 0;
      hold_left = HOLD_CYCLES;
      pulse     = 1;
      if (losses < LOSS_SAT) losses++;
    end
  endfunction

  task automatic check(string name, exp_t act, exp_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got rst_pix=%b ready=%b pulse=%b count=%0d, expected rst_pix=%b ready=%b pulse=%b count=%0d",
               name, $time, act.rst_pix, act.ready, act.lost_pulse, act.lost_count,
               exp.rst_pix, exp.ready, exp.lost_pulse, exp.lost_count);
    end
  endtask

  task automatic check_bit(string name, logic act, logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t: got %b, expected %b", name, $time, act, exp);
    end
  endtask

  task automatic step(bit lk);
    @(negedge clk);
    rst_n = 1'b1;
    clk_locked = lk;
    model_edge(lk);
    sb_q.push_back(model_out());
  endtask

  task automatic step_rst(bit lk);
    @(negedge clk);
    rst_n = 1'b0;
    clk_locked = lk;
    model_reset();
    sb_q.push_back(model_out());
  endtask

  task automatic hold(bit lk, int n);
    repeat (n) step(lk);
  endtask

  // Reset asserted between edges must be visible before the next rising edge.
  task automatic async_reset(string name);
    exp_t act;
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    model_reset();
    sb_q.push_back(model_out());
    #1;
    act = {rst_pix, ready, lost_pulse, lost_count};
    check(name, act, model_out());
  endtask

  initial begin : monitor
    exp_t act;
    forever begin
      @(posedge clk);
      #1;
      act = {rst_pix, ready, lost_pulse, lost_count};
      if (sb_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_empty t=%0t: got an output cycle, expected a queued prediction", $time);
      end else begin
        check("cycle", act, sb_q.pop_front());
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got no completion by t=%0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    model_reset();
    // Power-up with lock already high: release exactly SYNC_STAGES+STABLE_CYCLES edges after rst_n.
    repeat (5) step_rst(1'b1);
    hold(1'b1, 9);
    @(posedge clk); #2;
    check_bit("release_edge9_still_reset", rst_pix, 1'b1);
    step(1'b1);
    @(posedge clk); #2;
    check_bit("release_edge10_out_of_reset", rst_pix, 1'b0);
    hold(1'b1, 4);

    // Drop into WAIT_LOCK, then a glitch during qualification.
    hold(1'b0, 12);
    hold(1'b1, 5); hold(1'b0, 1); hold(1'b1, 14);

    // Loss in RUN lasting 3 cycles.
    hold(1'b0, 3); hold(1'b1, 20);

    // Repeated losses drive the counter into saturation.
    repeat (4) begin
      hold(1'b0, 2); hold(1'b1, 20);
    end

    // Lock returns one cycle after loss, while the hold is still running.
    hold(1'b0, 1); hold(1'b1, 20);

    // Async reset mid-qualification (count at 5) and mid-RUN with a nonzero loss count.
    async_reset("async_reset_setup");
    hold(1'b1, 7);
    async_reset("async_reset_mid_stable");
    hold(1'b1, 14);
    hold(1'b0, 1); hold(1'b1, 20);
    async_reset("async_reset_mid_run");
    hold(1'b1, 3);

    // Randomized lock waveform with occasional async resets.
    for (int seg = 0; seg < 70; seg++) begin
      bit lk;
      int len;
      lk  = ($urandom_range(0, 2) != 0);
      len = lk ? int'($urandom_range(1, 25)) : int'($urandom_range(1, 8));
      if ($urandom_range(0, 19) == 0) async_reset("async_reset_random");
      hold(lk, len);
    end

    @(posedge clk); #2;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
